// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Optional per-transfer abort watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 4095,
   localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ack,
   output logic               tx_start,
   output logic [DW-1:0]      tx_data,
   input  logic               tx_ready,
   output logic [GW-1:0]      grant_id,
   output logic               busy,
   output logic               timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   if (NREQ < 2 || NREQ > 8 || DW < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
   end

   state_t            r_state, w_state_nxt;
   logic [GW-1:0]     r_ptr, w_ptr_nxt;
   logic [NREQ-1:0]   r_ack, w_ack_nxt;
   logic              r_start, w_start_nxt;
   logic [DW-1:0]     r_data, w_data_nxt;
   logic [GW-1:0]     r_gid, w_gid_nxt;
   logic              w_found;
   logic [GW-1:0]     w_win;
`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0]       r_cnt, w_cnt_nxt;
   logic              r_terr, w_terr_nxt;
`endif

   // Scan from the slot after the last winner; descending offsets so the nearest valid one lands last.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_win   = '0;
      idx     = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(r_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[GW'(idx)]) begin
            w_found = 1'b1;
            w_win   = GW'(idx);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_ack_nxt   = '0;
      w_start_nxt = r_start;
      w_data_nxt  = r_data;
      w_gid_nxt   = r_gid;
`ifdef UART_ARB_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
      w_terr_nxt  = r_terr;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (tx_ready && w_found) begin
               w_ack_nxt[w_win] = 1'b1;
               w_start_nxt      = 1'b1;
               w_data_nxt       = req_data[w_win*DW +: DW];
               w_gid_nxt        = w_win;
               w_ptr_nxt        = w_win;
               w_state_nxt      = S_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
               w_cnt_nxt        = '0;
`endif
            end
         end
         S_ISSUE: begin
            if (!tx_ready) begin
               w_start_nxt = 1'b0;
               w_state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (tx_ready) w_state_nxt = S_IDLE;
         end
         default: begin
            w_start_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // Abort once the transfer has spent TIMEOUT cycles outside IDLE; overrides the handshake.
      if (r_state != S_IDLE) begin
         if (r_cnt == 16'(TIMEOUT - 1)) begin
            w_start_nxt = 1'b0;
            w_terr_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end else begin
            w_cnt_nxt = r_cnt + 16'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= GW'(NREQ - 1);
         r_ack   <= '0;
         r_start <= 1'b0;
         r_data  <= '0;
         r_gid   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         r_cnt   <= '0;
         r_terr  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_ack   <= w_ack_nxt;
         r_start <= w_start_nxt;
         r_data  <= w_data_nxt;
         r_gid   <= w_gid_nxt;
`ifdef UART_ARB_TIMEOUT_EN
         r_cnt   <= w_cnt_nxt;
         r_terr  <= w_terr_nxt;
`endif
      end
   end

   assign req_ack  = r_ack;
   assign tx_start = r_start;
   assign tx_data  = r_data;
   assign grant_id = r_gid;
   assign busy     = (r_state != S_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_err = r_terr;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences, and a randomized run
// against a transaction-level reference model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int TOUT = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   rv;
   logic [NREQ*DW-1:0] rd;
   logic              tx_ready;
   logic [NREQ-1:0]   req_ack;
   logic              tx_start;
   logic [DW-1:0]     tx_data;
   logic [1:0]        grant_id;
   logic              busy;
   logic              timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd),
      .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
      .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] ack, input logic st,
                          input logic bz, input logic [1:0] gid, input logic [7:0] dat);
      chk({tag, ".ack"},   32'(req_ack),  32'(ack));
      chk({tag, ".start"}, 32'(tx_start), 32'(st));
      chk({tag, ".busy"},  32'(busy),     32'(bz));
      chk({tag, ".gid"},   32'(grant_id), 32'(gid));
      chk({tag, ".data"},  32'(tx_data),  32'(dat));
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rv       = '0;
      tx_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] rv;
      logic       rdy;
      logic [3:0] ack;
      logic       start;
      logic       busy;
      logic [1:0] gid;
      logic [7:0] data;
   } vec_t;

   vec_t tbl[15];

   // reference model state (transaction level)
   bit              m_open, m_accepted;
   int              m_last, m_gid;
   logic [NREQ-1:0] m_ack;
   logic [DW-1:0]   m_data;
   int              tx_left, start_age;

   task automatic model_step();
      int best, bestd, d;
      m_ack = '0;
      if (!m_open) begin
         if (tx_ready && rv != '0) begin
            best  = 0;
            bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
               if (rv[i]) begin
                  d = (i - m_last - 1 + 2 * NREQ) % NREQ;
                  if (d < bestd) begin
                     bestd = d;
                     best  = i;
                  end
               end
            end
            m_ack      = 4'b0001 << best;
            m_open     = 1'b1;
            m_accepted = 1'b0;
            m_data     = rd[best*DW +: DW];
            m_gid      = best;
            m_last     = best;
         end
      end else if (!m_accepted) begin
         if (!tx_ready) m_accepted = 1'b1;
      end else if (tx_ready) begin
         m_open = 1'b0;
      end
   endtask

   initial begin
      bit seen;
      int exp_id;

      // reset state
      rst = 1'b1; rv = '0; rd = '0; tx_ready = 1'b0;
      tick();
      tick();
      chk_out("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("reset.terr", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // directed table: single grant, then 2 alone followed by 1010
      tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h41};
      tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h41};
      tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h41};
      tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h41};
      tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h41};
      tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h52};
      tbl[6]  = '{4'b1010, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h52};
      tbl[7]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h52};
      tbl[8]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 8'h52};
      tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h33};
      tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h33};
      tbl[11] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h33};
      tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h31};
      tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h31};
      tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h31};
      rd = 32'h33_52_31_41;
      for (int r = 0; r < 15; r++) begin
         rv       = tbl[r].rv;
         tx_ready = tbl[r].rdy;
         tick();
         chk_out($sformatf("tbl%0d", r), tbl[r].ack, tbl[r].start, tbl[r].busy,
                 tbl[r].gid, tbl[r].data);
      end

      // TX not ready out of reset: request waits
      do_reset();
      tx_ready = 1'b0;
      rv       = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_out("notready", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
      end
      tx_ready = 1'b1;
      tick();
      chk_out("ready_up", 4'b0100, 1'b1, 1'b1, 2'd2, 8'h52);
      rv = '0; tx_ready = 1'b0; tick();
      tx_ready = 1'b1; tick();

      // all four requesting: round-robin 0,1,2,3,0
      do_reset();
      rd = 32'hD3_C2_B1_A0;
      rv = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_id = k % NREQ;
         seen   = 1'b0;
         for (int c = 0; c < 10; c++) begin
            tick();
            if (req_ack != '0) begin
               seen = 1'b1;
               break;
            end
         end
         chk($sformatf("rr%0d.seen", k), 32'(seen), 32'd1);
         chk_out($sformatf("rr%0d", k), 4'b0001 << exp_id, 1'b1, 1'b1, 2'(exp_id),
                 rd[exp_id*DW +: DW]);
         tx_ready = 1'b0;
         tick();
         chk($sformatf("rr%0d.ack_once", k), 32'(req_ack), 32'd0);
         chk($sformatf("rr%0d.start_drop", k), 32'(tx_start), 32'd0);
         tick();
         tx_ready = 1'b1;
      end
      rv = '0;
      tick(); tick();

      // reset while waiting for the TX to finish
      do_reset();
      rd = 32'h33_52_31_41;
      rv = 4'b0100;
      tick();
      chk_out("rstw.grant", 4'b0100, 1'b1, 1'b1, 2'd2, 8'h52);
      rv = '0; tx_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("rstw.after", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
      rv = 4'b1111; tx_ready = 1'b1;
      tick();
      chk_out("rstw.next", 4'b0001, 1'b1, 1'b1, 2'd0, 8'h41);
      rv = '0; tx_ready = 1'b0; tick();
      tx_ready = 1'b1; tick();

      // randomized run against the reference model
      do_reset();
      m_open = 1'b0; m_accepted = 1'b0; m_last = NREQ - 1; m_gid = 0;
      m_ack = '0; m_data = '0; tx_left = 0; start_age = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         model_step();
         tick();
         chk("rnd.ack",   32'(req_ack),     32'(m_ack));
         chk("rnd.start", 32'(tx_start),    32'(m_open && !m_accepted));
         chk("rnd.busy",  32'(busy),        32'(m_open));
         chk("rnd.gid",   32'(grant_id),    32'(m_gid));
         chk("rnd.data",  32'(tx_data),     32'(m_data));
         chk("rnd.terr",  32'(timeout_err), 32'd0);
         for (int i = 0; i < NREQ; i++) begin
            if (m_ack[i]) rv[i] = 1'b0;
            if (!rv[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  rv[i]             = 1'b1;
                  rd[i*DW +: DW]    = DW'($urandom);
               end
            end else if ($urandom_range(0, 63) == 0) begin
               rv[i] = 1'b0;
            end
         end
         if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_ready = 1'b1;
         end else if (tx_start) begin
            start_age++;
            if (start_age >= 3 || $urandom_range(0, 1) == 0) begin
               tx_ready  = 1'b0;
               tx_left   = $urandom_range(1, 8);
               start_age = 0;
            end
         end else begin
            start_age = 0;
            if ($urandom_range(0, 15) == 0) begin
               tx_ready = 1'b0;
               tx_left  = $urandom_range(1, 3);
            end
         end
      end

      // TX never accepts: abort with the watchdog, otherwise wait forever
      do_reset();
      rd = 32'h33_52_31_41;
      rv = 4'b0001;
      tick();
      chk_out("to.grant", 4'b0001, 1'b1, 1'b1, 2'd0, 8'h41);
      rv = '0;
      for (int c = 0; c < TOUT - 1; c++) tick();
      chk("to.pre_start", 32'(tx_start), 32'd1);
      tick();
`ifdef UART_ARB_TIMEOUT_EN
      chk("to.start", 32'(tx_start),    32'd0);
      chk("to.terr",  32'(timeout_err), 32'd1);
      chk("to.busy",  32'(busy),        32'd0);
      tick();
      chk("to.sticky", 32'(timeout_err), 32'd1);
`else
      chk("to.start", 32'(tx_start),    32'd1);
      chk("to.terr",  32'(timeout_err), 32'd0);
      chk("to.busy",  32'(busy),        32'd1);
      for (int c = 0; c < 10; c++) tick();
      chk("to.still", 32'(tx_start), 32'd1);
`endif
      do_reset();
      chk("to.rst_terr", 32'(timeout_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
